// File: rtl/ysyx_22040127_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider FSM states,
// iteration counts and the op-flag bundle handed over by execute.
package ysyx_22040127_mdu_pkg;

  // Iteration counter is wide enough to hold the full 64-bit count.
  localparam int CNT_W = 7;
  typedef logic [CNT_W-1:0] div_cnt_t;

  localparam div_cnt_t DIV_ITER_D = 7'd64;  // doubleword ops
  localparam div_cnt_t DIV_ITER_W = 7'd32;  // *w ops

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Op flags as decoded by execute.
  typedef struct packed {
    logic is_signed;  // div/rem/divw/remw
    logic word;       // operate on bits [31:0]
    logic rem;        // return remainder instead of quotient
  } div_op_t;

  // Sign-extend a 32-bit value to 64 bits.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040127_div_step.sv
// One radix-2 restoring division iteration, purely combinational.
// {rem, quo} is shifted left by one; the divisor is trial-subtracted from the
// widened partial remainder and the subtraction is kept when it does not
// borrow, in which case the new quotient bit is 1.
module ysyx_22040127_div_step (
  input  logic [63:0] rem,
  input  logic [63:0] quo,
  input  logic [63:0] divisor,
  output logic [63:0] rem_nxt,
  output logic [63:0] quo_nxt
);

  logic [64:0] rem_sh;
  logic [63:0] quo_sh;
  logic [64:0] trial;

  // Shift, trial-subtract and restore.
  // The partial remainder before the shift is below the divisor, so the
  // shifted value is below twice the divisor and the true difference lies in
  // [-2^64, 2^64): a 65-bit result is exact and bit 64 is its sign.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    rem_sh  = {rem, quo[63]};
    quo_sh  = {quo[62:0], 1'b0};
    trial   = rem_sh - {1'b0, divisor};
    rem_nxt = rem_sh[63:0];
    quo_nxt = quo_sh;
    if (!trial[64]) begin
      rem_nxt = trial[63:0];
      quo_nxt = quo_sh | 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_22040127_div_ctrl.sv
// Multi-cycle RV64M divide/remainder sequencer for the execute stage.
// Accepts one op through a valid/ready handshake, runs a restoring divider
// one quotient bit per cycle and holds the final RV64 result until consumed.
// Only XLEN = 64 is supported.
module ysyx_22040127_div_ctrl
  import ysyx_22040127_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_signed,
  input  logic            in_word,
  input  logic            in_rem,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  div_state_e state, state_nxt;

  // Operation state, loaded at accept.
  div_cnt_t    cnt_q;
  logic [63:0] part_rem;
  logic [63:0] part_quo;
  logic [63:0] dsr_q;
  logic        neg_quo;
  logic        neg_rem;
  logic        word_q;
  logic        sel_rem_q;

  // Operand preparation.
  div_op_t     in_op;
  logic [63:0] src1_ext;
  logic [63:0] src2_ext;
  logic        src1_neg;
  logic        src2_neg;
  logic [63:0] abs1;
  logic [63:0] abs2;
  logic [63:0] quo_init;
  logic        div_zero;
  logic        accept;

  // Step and finalisation.
  logic [63:0] step_rem;
  logic [63:0] step_quo;
  logic [63:0] quo_fin;
  logic [63:0] rem_fin;
  logic [63:0] sel_fin;
  logic [63:0] result_fin;
  logic        last_iter;

  assign accept    = (state == IDLE) && in_valid && !flush;
  assign last_iter = (state == BUSY) && (cnt_q == '0);

  // Extend word operands, take absolute values for signed ops and record the
  // result signs. After extension bit 63 mirrors bit 31 for signed word ops,
  // so a single sign test covers both widths.
  always_comb begin
    in_op    = '{is_signed: in_signed, word: in_word, rem: in_rem};
    src1_ext = in_src1;
    src2_ext = in_src2;
    if (in_op.word) begin
      src1_ext = in_op.is_signed ? sext32(in_src1[31:0]) : {32'd0, in_src1[31:0]};
      src2_ext = in_op.is_signed ? sext32(in_src2[31:0]) : {32'd0, in_src2[31:0]};
    end
    src1_neg = in_op.is_signed && src1_ext[63];
    src2_neg = in_op.is_signed && src2_ext[63];
    abs1     = src1_neg ? -src1_ext : src1_ext;
    abs2     = src2_neg ? -src2_ext : src2_ext;
    // Word dividends sit in the upper half so that 32 shifts bring every
    // dividend bit through the remainder.
    quo_init = in_op.word ? {abs1[31:0], 32'd0} : abs1;
    div_zero = (src2_ext == 64'd0);
  end

  ysyx_22040127_div_step u_div_step (
    .rem     (part_rem),
    .quo     (part_quo),
    .divisor (dsr_q),
    .rem_nxt (step_rem),
    .quo_nxt (step_quo)
  );

  // Apply signs, pick quotient or remainder and form the RV64 word result.
  always_comb begin
    quo_fin    = neg_quo ? -part_quo : part_quo;
    rem_fin    = neg_rem ? -part_rem : part_rem;
    sel_fin    = sel_rem_q ? rem_fin : quo_fin;
    result_fin = word_q ? sext32(sel_fin[31:0]) : sel_fin;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  // A zero divisor loads a zero count, so it makes a single pass through
  // BUSY and presents its result one edge after accept, like the N+1 edges
  // of a normal op with N = 0.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = BUSY;
      BUSY: if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Handshake and status outputs, decoded from the state register only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Divider datapath: load at accept, one restoring step per BUSY cycle.
  always_ff @(posedge clk) begin
    // NOTE: the datapath has no reset; it is fully loaded at accept and only read while busy.
    if (accept) begin
      word_q    <= in_op.word;
      sel_rem_q <= in_op.rem;
      dsr_q     <= abs2;
      if (div_zero) begin
        // All-ones quotient and dividend remainder fall out of the normal
        // finalisation when no signs are applied.
        part_quo <= '1;
        part_rem <= src1_ext;
        neg_quo  <= 1'b0;
        neg_rem  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        part_quo <= quo_init;
        part_rem <= '0;
        neg_quo  <= src1_neg ^ src2_neg;
        neg_rem  <= src1_neg;
        cnt_q    <= in_op.word ? DIV_ITER_W : DIV_ITER_D;
      end
    end else if ((state == BUSY) && !last_iter) begin
      part_rem <= step_rem;
      part_quo <= step_quo;
      cnt_q    <= cnt_q - div_cnt_t'(1);
    end
  end

  // Result register: captured on entry to DONE, held while out_valid is high.
  always_ff @(posedge clk) begin
    if (rst)                     out_result <= '0;
    else if (last_iter && !flush) out_result <= result_fin;
  end

endmodule

// File: tb/tb_ysyx_22040127_div_ctrl.sv
// Directed self-checking bench for ysyx_22040127_div_ctrl.
module tb_ysyx_22040127_div_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic        in_word;
  logic        in_rem;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ysyx_22040127_div_ctrl #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_word    (in_word),
    .in_rem     (in_rem),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one op for a single cycle; returns #1 after the accept edge.
  task automatic start_op(input logic s, input logic w, input logic r,
                          input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_signed = s;
    in_word   = w;
    in_rem    = r;
    in_src1   = a;
    in_src2   = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  // Count edges after accept until out_valid is seen (bounded), then check
  // latency and result.
  task automatic wait_result(input string tag, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, out_result, exp_res);
  endtask

  // Consume the result and confirm the block is ready again next cycle.
  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic s, input logic w, input logic r,
                        input logic [63:0] a, input logic [63:0] b,
                        input int exp_lat, input logic [63:0] exp_res);
    start_op(s, w, r, a, b);
    wait_result(tag, exp_lat, exp_res);
    consume(tag);
  endtask

  initial begin
    int seen;
    int unstable;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_word   = 1'b0;
    in_rem    = 1'b0;
    in_src1   = '0;
    in_src2   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready",   64'(in_ready),  64'd1);
    check("rst_out_valid",  64'(out_valid), 64'd0);
    check("rst_out_result", out_result,     64'd0);
    check("rst_busy",       64'(busy),      64'd0);

    // divu / remu 100 / 7, with in_ready low right after accept.
    start_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    check("divu_in_ready_low", 64'(in_ready), 64'd0);
    wait_result("divu_100_7", 65, 64'd14);
    consume("divu_100_7");
    run_op("remu_100_7", 1'b0, 1'b0, 1'b1, 64'd100, 64'd7, 65, 64'd2);

    // Signed: -7 / 2 -> -3 rem -1.
    run_op("div_m7_2", 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_m7_2", 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);

    // Word and doubleword signed overflow.
    run_op("divw_ovf", 1'b1, 1'b1, 1'b0, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 33, 64'hFFFF_FFFF_8000_0000);
    run_op("remw_ovf", 1'b1, 1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 33, 64'd0);
    run_op("div_ovf",  1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'h8000_0000_0000_0000);

    // divuw result is still sign-extended from bit 31.
    run_op("divuw_sext", 1'b0, 1'b1, 1'b0, 64'h1234_5678_FFFF_FFFF, 64'd1, 33, 64'hFFFF_FFFF_FFFF_FFFF);

    // Divide by zero.
    run_op("divu_z", 1'b0, 1'b0, 1'b0, 64'd55, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remw_z", 1'b1, 1'b1, 1'b1, 64'h0000_0001_8000_0005, 64'd0, 1, 64'hFFFF_FFFF_8000_0005);

    // Flush mid-operation at cycle 20.
    start_op(1'b1, 1'b0, 1'b0, 64'd1000, 64'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy",     64'(busy),     64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    run_op("after_flush", 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, 65, 64'd14);

    // flush together with in_valid in IDLE: op is not accepted.
    @(negedge clk);
    in_src1  = 64'd9;
    in_src2  = 64'd3;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_vs_valid_busy", 64'(busy), 64'd0);

    // Backpressure: DONE holds while out_ready is low.
    start_op(1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    wait_result("bp", 65, 64'd14);
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!out_valid || out_result !== 64'd14 || in_ready) unstable++;
    end
    check("bp_stable", 64'(unstable), 64'd0);
    consume("bp");
    check("bp_valid_dropped", 64'(out_valid), 64'd0);

    // flush together with out_ready in DONE: back to IDLE.
    start_op(1'b0, 1'b0, 1'b1, 64'd23, 64'd5);
    wait_result("flush_done", 65, 64'd3);
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_done_idle", 64'(in_ready), 64'd1);

    // rst mid-operation also clears out_result.
    start_op(1'b0, 1'b0, 1'b0, 64'd500, 64'd4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_busy",   64'(busy),  64'd0);
    check("rst_mid_result", out_result, 64'd0);
    run_op("after_rst", 1'b1, 1'b0, 1'b0, 64'd500, 64'hFFFF_FFFF_FFFF_FFFC, 65, 64'hFFFF_FFFF_FFFF_FF83);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040127_div_ctrl.md
# ysyx_22040127_div_ctrl

Multi-cycle sequencer for RV64M division and remainder (div, divu, rem, remu, divw, divuw, remw, remuw). It replaces the single-cycle `/` and `%` operators in the execute stage. Execute hands over operands with a valid/ready handshake and holds its ready_go low until this block returns a result. The block runs a radix-2 restoring divider one quotient bit per cycle, handles the RISC-V divide-by-zero and signed-overflow cases, and supports a pipeline flush.

## Interface
- XLEN, 64, datapath width; only 64 is supported.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  execute presents a division op
- in_ready  out  1  block can accept an op
- in_signed  in  1  1 = div/rem/divw/remw; 0 = unsigned variants
- in_word  in  1  1 = *w op, operates on bits [31:0]
- in_rem  in  1  1 = return remainder; 0 = return quotient
- in_src1  in  XLEN  dividend
- in_src2  in  XLEN  divisor
- flush  in  1  abort any op in flight
- out_valid  out  1  result available
- out_ready  in  1  execute consumes the result (ex_ready_go && mem_allowin)
- out_result  out  XLEN  quotient or remainder, final RV64 form
- busy  out  1  state != IDLE

## Operation
- States and transitions:
  - IDLE: in_ready=1. On in_valid && !flush, latch the op and go to BUSY. If divisor==0, go directly to DONE instead.
  - BUSY: perform one restoring step per cycle. The counter loads N = 64, or 32 when in_word, and decrements. When the counter reaches 0, go to DONE.
  - DONE: out_valid=1 and out_result is held stable. On out_ready, go to IDLE.
  - Any state: flush forces IDLE on the next edge and drops any partial result.
- Operand preparation at accept:
  - Word ops: sign-extend src[31:0] if in_signed, otherwise zero-extend.
  - Signed ops: divide absolute values.
  - Record neg_q = sign(src1) ^ sign(src2) and neg_r = sign(src1), using bit 31 for word ops and bit 63 otherwise.
- Restoring step:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor, computed at 65 bits.
  - If trial is non-negative: rem = trial and set quo[0] = 1.
- Finalisation, applied when entering DONE:
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Select the quotient or remainder per in_rem.
  - Word ops: sign-extend the selected value from bit 31. This applies to divuw and remuw as well.
- Divide by zero: quotient = all ones (after the word sign-extension rule), remainder = src1 (word ops: sext of src1[31:0]).
- Signed overflow (most-negative / -1): quotient = dividend, remainder = 0. The absolute-value path produces this without a special case; verify it explicitly.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, busy=0.
- Latency, counting the accept edge as edge 0:
  - out_valid rises after edge N+1, where N is 64 or 32 per the state rules above.
  - Divide-by-zero: out_valid rises after edge 1.
- Throughput: one op in flight. in_ready is 0 from the cycle after accept until the cycle after the DONE handshake. An op cannot be accepted in the same cycle a result is consumed.
- out_valid and out_result are registered, with no combinational path from in_* to out_*.
- Simultaneous events:
  - flush with in_valid in IDLE: flush wins and the op is not accepted.
  - flush with out_ready in DONE: return to IDLE; the result counts as dropped.
- Backpressure: DONE holds indefinitely while out_ready=0.
- rst mid-operation: behaves exactly like flush and also clears out_result.

## Structure
- Shared package ysyx_22040127_mdu_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - iteration-count constants (64 and 32)
  - the op-flag bundle (signed, word, rem)
- One sub-module: ysyx_22040127_div_step. It is purely combinational: one restoring iteration, with inputs {rem, quo, divisor} and outputs {rem', quo'}.
- The FSM, counter and the sign/finalisation logic stay in the top module.

## Test plan
- divu, src1=100, src2=7: out_result=14, out_valid exactly 65 cycles after accept. The same operands with remu: result=2.
- div, src1=-7, src2=2: result 0xFFFF_FFFF_FFFF_FFFD (-3). rem with the same operands: 0xFFFF_FFFF_FFFF_FFFF (-1).
- divw, src1=0x0000_0001_8000_0000, src2=-1 (word overflow): result 0xFFFF_FFFF_8000_0000 after 33 cycles. remw with the same operands: result 0.
- divu with src2=0: result all ones, valid 1 cycle after accept. remw with src1=0x1_8000_0005, src2=0: result 0xFFFF_FFFF_8000_0005.
- Start div, pulse flush at cycle 20: next cycle state is IDLE and in_ready=1. out_valid never rises. A following op completes correctly.
- Complete divu 100/7, hold out_ready=0 for 10 cycles: out_valid and out_result=14 stay stable and in_ready stays 0. After out_ready=1, in_ready=1 on the next cycle.
